seq_shifter: RTL and testbench

- Multi-cycle, parametrised shifter/rotator; next generation of the fixed shift-left-by-two unit in the CPU datapath.
- Accepts an operand, shift amount and mode through a start/ready handshake; shifts by up to STEP bits per clock.
- Returns the result with a one-cycle done pulse.
- Used by the multi-cycle ALU path for SLL/SRL/SRA/rotate instructions.

---
 rtl/seq_shifter.sv | 136 +++++++++++++
 tb/tb_seq_shifter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator: accepts one operation per start/ready handshake and
// shifts the latched operand by up to STEP bits per clock, then pulses done_o.
module seq_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [SHW-1:0]   shamt_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] MODE_SLL  = 2'b00;
    localparam logic [1:0] MODE_SRL  = 2'b01;
    localparam logic [1:0] MODE_SRA  = 2'b10;
    localparam logic [1:0] MODE_ROTL = 2'b11;

    // Step and width need one extra bit: STEP may equal WIDTH.
    localparam logic [SHW:0] STEP_W  = (SHW+1)'(STEP);
    localparam logic [SHW:0] WIDTH_W = (SHW+1)'(WIDTH);

    state_t           state_r;
    logic             ready_r;
    logic             done_r;
    logic [WIDTH-1:0] work_r;
    logic [SHW:0]     rem_r;
    logic [1:0]       mode_r;
    logic             sign_r;

    logic [SHW:0]     step_s;
    logic [SHW:0]     rem_next_s;
    logic [WIDTH-1:0] work_next_s;

    // One partial shift; amt is always below WIDTH when used, sign is the operand MSB at accept.
    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0] val,
        input logic [SHW:0]     amt,
        input logic [1:0]       mode,
        input logic             sign
    );
        logic [WIDTH-1:0] fill_mask;
        fill_mask = ~({WIDTH{1'b1}} >> amt);
        case (mode)
            MODE_SLL:  shift_by = val << amt;
            MODE_SRL:  shift_by = val >> amt;
            MODE_SRA:  shift_by = (val >> amt) | (sign ? fill_mask : {WIDTH{1'b0}});
            MODE_ROTL: shift_by = (val << amt) | (val >> (WIDTH_W - amt));
            default:   shift_by = val;
        endcase
    endfunction

    // Per-cycle step size min(rem, STEP) and the resulting work/remaining values.
    always_comb begin
        step_s      = {(SHW+1){1'b0}};
        rem_next_s  = rem_r;
        work_next_s = work_r;
        if (rem_r > STEP_W) begin
            step_s = STEP_W;
        end else begin
            step_s = rem_r;
        end
        rem_next_s  = rem_r - step_s;
        work_next_s = shift_by(work_r, step_s, mode_r, sign_r);
    end

    // Control FSM with registered handshake outputs and the shifting work register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            work_r  <= {WIDTH{1'b0}};
            rem_r   <= {(SHW+1){1'b0}};
            mode_r  <= MODE_SLL;
            sign_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start_i) begin
                        work_r  <= data_i;
                        mode_r  <= mode_i;
                        sign_r  <= data_i[WIDTH-1];
                        rem_r   <= {1'b0, shamt_i};
                        ready_r <= 1'b0;
                        if (shamt_i != {SHW{1'b0}}) begin
                            state_r <= ST_SHIFT;
                        end else begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    work_r <= work_next_s;
                    rem_r  <= rem_next_s;
                    if (rem_next_s == {(SHW+1){1'b0}}) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o = ready_r;
    assign done_o  = done_r;
    assign data_o  = work_r;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: STEP=4, STEP=1 and STEP=32 builds share one stimulus stream and
// are checked every cycle against a shift-by-shamt model, plus directed literal results.
module tb_seq_shifter;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       mode;
    logic [4:0]       shamt;
    logic [31:0]      data;
    logic [2:0]       rdy;
    logic [2:0]       dn;
    logic [2:0][31:0] dq;

    int total = 0;
    int bad   = 0;

    int          lat [3];
    logic [31:0] dval [3];

    bit          m_busy [3];
    int          m_cyc [3];
    int          m_k [3];
    logic [31:0] m_res [3];
    logic [31:0] m_out [3];

    seq_shifter #(.WIDTH(32), .STEP(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .mode_i(mode), .shamt_i(shamt),
        .data_i(data), .ready_o(rdy[0]), .done_o(dn[0]), .data_o(dq[0])
    );
    seq_shifter #(.WIDTH(32), .STEP(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .mode_i(mode), .shamt_i(shamt),
        .data_i(data), .ready_o(rdy[1]), .done_o(dn[1]), .data_o(dq[1])
    );
    seq_shifter #(.WIDTH(32), .STEP(32)) u_dut32 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .mode_i(mode), .shamt_i(shamt),
        .data_i(data), .ready_o(rdy[2]), .done_o(dn[2]), .data_o(dq[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int step_of(input int i);
        if (i == 0) return 4;
        else if (i == 1) return 1;
        else return 32;
    endfunction

    // Whole shift in one go, straight from the operation definitions.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [1:0] m, input int s);
        logic [63:0] dd;
        case (m)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 32'($signed(d) >>> s);
            default: begin
                dd = {d, d} << s;
                return dd[63:32];
            end
        endcase
    endfunction

    // Model: an accepted op finishes ceil(shamt/STEP) edges later, then one more edge to idle.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_busy[i] <= 1'b0;
                m_cyc[i]  <= 0;
                m_k[i]    <= 0;
                m_res[i]  <= 32'h0;
                m_out[i]  <= 32'h0;
            end else if (!m_busy[i]) begin
                if (start) begin
                    m_busy[i] <= 1'b1;
                    m_cyc[i]  <= 0;
                    m_k[i]    <= (int'(shamt) + step_of(i) - 1) / step_of(i);
                    m_res[i]  <= ref_shift(data, mode, int'(shamt));
                end
            end else if (m_cyc[i] == m_k[i]) begin
                m_busy[i] <= 1'b0;
                m_out[i]  <= m_res[i];
            end else begin
                m_cyc[i] <= m_cyc[i] + 1;
            end
        end
    end

    // Every-cycle comparison of all three builds against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic        exp_done;
            logic [31:0] exp_d;
            exp_done = m_busy[i] && (m_cyc[i] == m_k[i]);
            total++;
            if (rdy[i] !== !m_busy[i]) begin
                bad++;
                $display("FAIL ready_o[%0d] actual=%b required=%b t=%0t", i, rdy[i], !m_busy[i], $time);
            end
            total++;
            if (dn[i] !== exp_done) begin
                bad++;
                $display("FAIL done_o[%0d] actual=%b required=%b t=%0t", i, dn[i], exp_done, $time);
            end
            if (!m_busy[i] || exp_done) begin
                exp_d = exp_done ? m_res[i] : m_out[i];
                total++;
                if (dq[i] !== exp_d) begin
                    bad++;
                    $display("FAIL data_o[%0d] actual=%h required=%h t=%0t", i, dq[i], exp_d, $time);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (rdy !== 3'b111 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("wait_idle", 32'(rdy), 32'h7);
    endtask

    // Issue one op; record per-build latency (edges after accept) and result at done.
    task automatic run_op(input string name, input logic [31:0] d, input logic [1:0] m,
                          input logic [4:0] s, input logic [31:0] exp_d, input int exp_k);
        int  e;
        bit  all_seen;
        wait_idle();
        start = 1'b1; data = d; mode = m; shamt = s;
        for (int i = 0; i < 3; i++) begin
            lat[i]  = -1;
            dval[i] = 32'hx;
        end
        @(negedge clk);
        start = 1'b0;
        e = 0;
        all_seen = 1'b0;
        while (!all_seen && e < 80) begin
            for (int i = 0; i < 3; i++) begin
                if (lat[i] < 0 && dn[i]) begin
                    lat[i]  = e;
                    dval[i] = dq[i];
                end
            end
            all_seen = (lat[0] >= 0) && (lat[1] >= 0) && (lat[2] >= 0);
            if (!all_seen) begin
                @(negedge clk);
                e++;
            end
        end
        chk({name, "_latency"}, 32'(lat[0]), 32'(exp_k));
        chk({name, "_data"}, dval[0], exp_d);
    endtask

    initial begin
        int          n_rdy;
        int          n_dn;
        int          done_e;
        logic [31:0] v;

        rst_n = 1'b0; start = 1'b0; mode = 2'b00; shamt = 5'd0; data = 32'h0;
        #7;
        chk("reset_ready", 32'(rdy[0]), 32'h1);
        chk("reset_done", 32'(dn[0]), 32'h0);
        chk("reset_data", dq[0], 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("sll2", 32'h0000_0001, 2'b00, 5'd2, 32'h0000_0004, 1);
        run_op("sra31", 32'h8000_00F0, 2'b10, 5'd31, 32'hFFFF_FFFF, 8);
        run_op("srl31", 32'h8000_00F0, 2'b01, 5'd31, 32'h0000_0001, 8);
        run_op("rotl8", 32'h1234_5678, 2'b11, 5'd8, 32'h3456_7812, 2);
        run_op("rotl0", 32'h1234_5678, 2'b11, 5'd0, 32'h1234_5678, 0);
        run_op("sra_pos", 32'h7000_0000, 2'b10, 5'd3, 32'h0E00_0000, 1);
        run_op("srl4", 32'hF000_000F, 2'b01, 5'd4, 32'h0F00_0000, 1);
        run_op("rotl13", 32'h8000_0001, 2'b11, 5'd13, 32'h0000_3000, 4);

        run_op("sll5", 32'hFFFF_FFFF, 2'b00, 5'd5, 32'hFFFF_FFE0, 2);
        chk("step1_latency", 32'(lat[1]), 32'd5);
        chk("step1_data", dval[1], 32'hFFFF_FFE0);
        chk("step32_latency", 32'(lat[2]), 32'd1);
        chk("step32_data", dval[2], 32'hFFFF_FFE0);

        // Starts while busy must be dropped, not queued.
        wait_idle();
        start = 1'b1; data = 32'h0000_0FFF; mode = 2'b00; shamt = 5'd20;
        @(negedge clk);
        n_rdy = 0; n_dn = 0; done_e = -1; v = 32'h0;
        for (int e = 0; e < 6; e++) begin
            if (rdy[0]) n_rdy++;
            if (dn[0]) begin
                n_dn++;
                v = dq[0];
                done_e = e;
            end
            start = (e == 1 || e == 4);
            if (start) begin
                data = 32'hDEAD_BEEF; mode = 2'b11; shamt = 5'd1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_ready_low", 32'(n_rdy), 32'd0);
        chk("busy_done_edge", 32'(done_e), 32'd5);
        chk("busy_done_count", 32'(n_dn), 32'd1);
        chk("busy_result", v, 32'hFFF0_0000);
        n_dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (dn[0]) n_dn++;
        end
        chk("busy_no_second_done", 32'(n_dn), 32'd0);
        chk("busy_result_held", dq[0], 32'hFFF0_0000);

        // Start held high: one op per k+2 cycles.
        wait_idle();
        start = 1'b1; data = 32'h0000_0001; mode = 2'b00; shamt = 5'd4;
        n_dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (dn[0]) n_dn++;
        end
        start = 1'b0;
        chk("b2b_done_count", 32'(n_dn), 32'd4);

        // Asynchronous reset in the middle of a long shift.
        wait_idle();
        start = 1'b1; data = 32'hFFFF_FFFF; mode = 2'b00; shamt = 5'd31;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_ready", 32'(rdy), 32'h7);
        chk("midreset_done", 32'(dn), 32'h0);
        chk("midreset_data", dq[0], 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (dn != 3'b000) n_dn++;
        end
        chk("midreset_no_done", 32'(n_dn), 32'd0);
        run_op("post_reset_srl4", 32'h0000_00FF, 2'b01, 5'd4, 32'h0000_000F, 1);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
